// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/done handshake.
// Define SIGNED_DIV_EN for two's-complement operands (truncating quotient, remainder
// takes the dividend's sign).
module seq_restoring_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [0:WIDTH-1] dividend,
    input  logic [0:WIDTH-1] divisor,
    output logic             busy,
    output logic             done,
    output logic [0:WIDTH-1] quotient,
    output logic [0:WIDTH-1] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [WIDTH+1:0] SumOne = 1;

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    // Stored partial remainder is always below the divisor, so WIDTH bits suffice;
    // the trial subtract itself runs at WIDTH+1 bits on the shifted value.
    logic [WIDTH-1:0]  part_q, part_d;
    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [WIDTH-1:0]  dsr_q, dsr_d;
    logic [WIDTH-1:0]  quot_q, quot_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic              dbz_q, dbz_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic [WIDTH-1:0]  dvd, dvs;
    logic [WIDTH:0]    shifted;
    logic [WIDTH+1:0]  sum;
    logic              carry;
    logic [WIDTH-1:0]  part_next;
    logic [WIDTH-1:0]  quot_raw;
    logic [WIDTH-1:0]  quot_fin, rem_fin;
    logic [WIDTH-1:0]  dvd_mag, dvs_mag;
    logic              unused_sum_msb;

    assign dvd = dividend;
    assign dvs = divisor;

`ifdef SIGNED_DIV_EN
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x) + WIDTH'(1) : x;
    endfunction
`endif

    // Trial subtract: shifted + ~{0,divisor} + 1; carry-out means no borrow.
    always_comb begin
        shifted   = {part_q, shreg_q[WIDTH-1]};
        sum       = {1'b0, shifted} + {1'b0, ~{1'b0, dsr_q}} + SumOne;
        carry     = sum[WIDTH+1];
        part_next = carry ? sum[WIDTH-1:0] : shifted[WIDTH-1:0];
        quot_raw  = {shreg_q[WIDTH-2:0], carry};
`ifdef SIGNED_DIV_EN
        dvd_mag   = mag(dvd);
        dvs_mag   = mag(dvs);
        quot_fin  = neg_quo_q ? (~quot_raw) + WIDTH'(1) : quot_raw;
        rem_fin   = neg_rem_q ? (~part_next) + WIDTH'(1) : part_next;
`else
        dvd_mag   = dvd;
        dvs_mag   = dvs;
        quot_fin  = quot_raw;
        rem_fin   = part_next;
`endif
    end

    // Top sum bit is zero whenever the trial result is kept (result < divisor).
    assign unused_sum_msb = sum[WIDTH];

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        part_d  = part_q;
        shreg_d = shreg_q;
        dsr_d   = dsr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        busy_d  = 1'b0;
`ifdef SIGNED_DIV_EN
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            StIdle, StFin: begin
                if (state_q == StFin) begin
                    state_d = StIdle;
                end
                if (start) begin
                    if (dvs == '0) begin
                        state_d = StFin;
                        done_d  = 1'b1;
                        quot_d  = '1;
                        rem_d   = dvd;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = StRun;
                        busy_d  = 1'b1;
                        part_d  = '0;
                        count_d = CntW'(WIDTH);
                        shreg_d = dvd_mag;
                        dsr_d   = dvs_mag;
`ifdef SIGNED_DIV_EN
                        neg_quo_d = dvd[WIDTH-1] ^ dvs[WIDTH-1];
                        neg_rem_d = dvd[WIDTH-1];
`endif
                    end
                end
            end
            StRun: begin
                part_d  = part_next;
                shreg_d = quot_raw;
                count_d = count_q - CntW'(1);
                if (count_q == CntW'(1)) begin
                    state_d = StFin;
                    done_d  = 1'b1;
                    quot_d  = quot_fin;
                    rem_d   = rem_fin;
                    dbz_d   = 1'b0;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= '0;
            part_q  <= '0;
            shreg_q <= '0;
            dsr_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            part_q  <= part_d;
            shreg_q <= shreg_d;
            dsr_q   <= dsr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef SIGNED_DIV_EN
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
